// File: rtl/store_align_unit.sv
// Store alignment unit: lane-replicates store data, builds byte enables and runs one
// valid/ready + ack data-memory write. Define MISALIGN_SPLIT_EN to split misaligned stores.
module store_align_unit #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TMR_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [1:0]  req_size_i,
  output logic        done_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i
);

  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam bit TMO_EN = (ACK_TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_EN ? ACK_TIMEOUT - 32'd1 : 32'd0);

  typedef enum logic [2:0] {
    S_IDLE, S_REJECT, S_ISSUE, S_WAIT_ACK, S_DONE, S_ERR, S_ISSUE2, S_WAIT_ACK2
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              ready_q, valid_q, done_q, mis_q, err_q;
  logic [DW-1:0]     addr_q, wdata_q;
  logic [BEW-1:0]    be_q;

  logic [1:0]        lane;
  logic              misaligned, reject, accept, load_b1, load_b2, tmo_hit, in_wait;
  logic [DW-1:0]     acc_wdata;
  logic [BEW-1:0]    acc_be;

`ifdef MISALIGN_SPLIT_EN
  logic              split_q;
  logic [DW-1:0]     data_q;
  logic [1:0]        lane_q;
  logic [BEW-1:0]    mask_q;
  logic [BEW-1:0]    size_mask;
  logic [DW-1:0]     b2_addr, b2_wdata;
  logic [BEW-1:0]    b2_be;
`endif

  // Lane placement and byte enables for the incoming request
  always_comb begin
    lane       = req_addr_i[1:0];
    misaligned = (req_size_i == SZ_ILL) ||
                 ((req_size_i == SZ_HALF) && lane[0]) ||
                 ((req_size_i == SZ_WORD) && (lane != 2'b00));
    case (req_size_i)
      SZ_BYTE: begin
        acc_wdata = {4{req_data_i[7:0]}};
        acc_be    = 4'b0001 << lane;
      end
      SZ_HALF: begin
        acc_wdata = {2{req_data_i[15:0]}};
        acc_be    = 4'b0011 << lane;
      end
      default: begin
        acc_wdata = req_data_i;
        acc_be    = 4'b1111;
      end
    endcase
`ifdef MISALIGN_SPLIT_EN
    size_mask = (req_size_i == SZ_HALF) ? 4'b0011 : 4'b1111;
    reject    = (req_size_i == SZ_ILL);
    // Split beat 1: shifted without replication, upper lanes spill into beat 2
    if (misaligned && !reject) begin
      acc_wdata = req_data_i << {lane, 3'b000};
      acc_be    = size_mask << lane;
    end
    b2_addr  = addr_q + 32'd4;
    b2_be    = mask_q >> (3'd4 - {1'b0, lane_q});
    b2_wdata = data_q >> (6'd32 - {1'b0, lane_q, 3'b000});
`else
    reject    = misaligned;
`endif
  end

  // Next-state logic and timeout counter
  always_comb begin
    state_d = state_q;
    accept  = (state_q == S_IDLE) && req_valid_i;
    load_b1 = accept && !reject;
    load_b2 = 1'b0;
    in_wait = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_ACK2);
    tmr_d   = in_wait ? tmr_q + TMR_W'(1) : '0;
    tmo_hit = TMO_EN && (tmr_q == TMO_LAST);
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = reject ? S_REJECT : S_ISSUE;
      end
      S_REJECT, S_DONE, S_ERR: state_d = S_IDLE;
      S_ISSUE: begin
        if (bus_ready_i) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus_ack_i) begin
`ifdef MISALIGN_SPLIT_EN
          load_b2 = split_q;
          state_d = split_q ? S_ISSUE2 : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_ISSUE2: begin
        if (bus_ready_i) state_d = S_WAIT_ACK2;
      end
      S_WAIT_ACK2: begin
        if (bus_ack_i)    state_d = S_DONE;
        else if (tmo_hit) state_d = S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered status pulses and bus payload
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ready_q <= (state_d == S_IDLE);
      valid_q <= (state_d == S_ISSUE) || (state_d == S_ISSUE2);
      done_q  <= (state_d == S_DONE);
      mis_q   <= (state_d == S_REJECT);
      err_q   <= (state_d == S_ERR);
      if (load_b1) begin
        addr_q  <= {req_addr_i[31:2], 2'b00};
        wdata_q <= acc_wdata;
        be_q    <= acc_be;
      end
`ifdef MISALIGN_SPLIT_EN
      else if (load_b2) begin
        addr_q  <= b2_addr;
        wdata_q <= b2_wdata;
        be_q    <= b2_be;
      end
`endif
    end
  end

`ifdef MISALIGN_SPLIT_EN
  // Request fields kept for building the second beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      split_q <= 1'b0;
      data_q  <= '0;
      lane_q  <= '0;
      mask_q  <= '0;
    end else if (load_b1) begin
      split_q <= misaligned;
      data_q  <= req_data_i;
      lane_q  <= lane;
      mask_q  <= size_mask;
    end
  end
`endif

  assign req_ready_o = ready_q;
  assign bus_valid_o = valid_q;
  assign done_o      = done_q;
  assign misalign_o  = mis_q;
  assign err_o       = err_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: vector table for single stores, plus hand-written
// timeout, reset and (with MISALIGN_SPLIT_EN) split-store sequences.
module tb_store_align_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [1:0]  req_size_i;
  logic        done_o, misalign_o, err_o;
  logic        bus_valid_o;
  logic        bus_ready_i;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  int mis_cnt  = 0;
  int err_cnt  = 0;

  store_align_unit #(.ACK_TIMEOUT(4), .TMR_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_size_i(req_size_i),
    .done_o(done_o), .misalign_o(misalign_o), .err_o(err_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o)     done_cnt++;
    if (misalign_o) mis_cnt++;
    if (err_o)      err_cnt++;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        rej;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
    int          hold;
    int          ack_dly;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] d, logic [1:0] s, logic r,
                              logic [31:0] ea, logic [31:0] ew, logic [3:0] eb,
                              int h, int ad);
    vec_t v;
    v.addr = a; v.data = d; v.size = s; v.rej = r;
    v.eaddr = ea; v.ewdata = ew; v.ebe = eb; v.hold = h; v.ack_dly = ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_size_i  = s;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = 32'h5A5A_5A5A;
    req_data_i  = 32'hFFFF_FFFF;
    req_size_i  = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int d0, m0;
    d0 = done_cnt;
    m0 = mis_cnt;
    send(v.addr, v.data, v.size);
    if (v.rej) begin
      chk($sformatf("v%0d misalign", idx), 32'(misalign_o), 32'd1);
      chk($sformatf("v%0d rej_valid", idx), 32'(bus_valid_o), 32'd0);
      chk($sformatf("v%0d rej_ready", idx), 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      chk($sformatf("v%0d misalign_end", idx), 32'(misalign_o), 32'd0);
      chk($sformatf("v%0d ready_after", idx), 32'(req_ready_o), 32'd1);
      chk($sformatf("v%0d mis_count", idx), 32'(mis_cnt - m0), 32'd1);
      chk($sformatf("v%0d no_done", idx), 32'(done_cnt - d0), 32'd0);
    end else begin
      for (int h = 0; h <= v.hold; h++) begin
        chk($sformatf("v%0d valid c%0d", idx, h), 32'(bus_valid_o), 32'd1);
        chk($sformatf("v%0d addr c%0d", idx, h), bus_addr_o, v.eaddr);
        chk($sformatf("v%0d wdata c%0d", idx, h), bus_wdata_o, v.ewdata);
        chk($sformatf("v%0d be c%0d", idx, h), 32'(bus_be_o), 32'(v.ebe));
        if (h < v.hold) @(negedge clk_i);
      end
      chk($sformatf("v%0d busy_ready", idx), 32'(req_ready_o), 32'd0);
      bus_ready_i = 1'b1;
      @(negedge clk_i);
      bus_ready_i = 1'b0;
      chk($sformatf("v%0d valid_drop", idx), 32'(bus_valid_o), 32'd0);
      repeat (v.ack_dly) @(negedge clk_i);
      bus_ack_i = 1'b1;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      chk($sformatf("v%0d done", idx), 32'(done_o), 32'd1);
      chk($sformatf("v%0d err_excl", idx), 32'(err_o), 32'd0);
      @(negedge clk_i);
      chk($sformatf("v%0d done_end", idx), 32'(done_o), 32'd0);
      chk($sformatf("v%0d ready_after", idx), 32'(req_ready_o), 32'd1);
      chk($sformatf("v%0d done_count", idx), 32'(done_cnt - d0), 32'd1);
    end
  endtask

  // Word store never acked (optionally acked during the ISSUE handshake, which must be ignored)
  task automatic run_timeout(input logic ack_in_issue);
    int d0;
    d0 = done_cnt;
    send(32'h0000_4000, 32'h1122_3344, 2'b10);
    chk("tmo valid", 32'(bus_valid_o), 32'd1);
    bus_ready_i = 1'b1;
    bus_ack_i   = ack_in_issue;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
    bus_ack_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo wait%0d err", i), 32'(err_o), 32'd0);
      @(negedge clk_i);
    end
    chk("tmo err", 32'(err_o), 32'd1);
    chk("tmo done_excl", 32'(done_o), 32'd0);
    chk("tmo ready_low", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    chk("tmo err_end", 32'(err_o), 32'd0);
    chk("tmo ready_after", 32'(req_ready_o), 32'd1);
    chk("tmo no_done", 32'(done_cnt - d0), 32'd0);
  endtask

`ifdef MISALIGN_SPLIT_EN
  task automatic run_split();
    int d0;
    d0 = done_cnt;
    send(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10);
    chk("split b1 valid", 32'(bus_valid_o), 32'd1);
    chk("split b1 addr", bus_addr_o, 32'hFFFF_FFFC);
    chk("split b1 be", 32'(bus_be_o), 32'hC);
    chk("split b1 wdata", bus_wdata_o, 32'hC3D4_0000);
    bus_ready_i = 1'b1;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
    bus_ack_i   = 1'b1;
    @(negedge clk_i);
    bus_ack_i   = 1'b0;
    chk("split b1 no_done", 32'(done_o), 32'd0);
    chk("split b2 valid", 32'(bus_valid_o), 32'd1);
    chk("split b2 addr", bus_addr_o, 32'h0000_0000);
    chk("split b2 be", 32'(bus_be_o), 32'h3);
    chk("split b2 wdata", bus_wdata_o, 32'h0000_A1B2);
    bus_ready_i = 1'b1;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
    bus_ack_i   = 1'b1;
    @(negedge clk_i);
    bus_ack_i   = 1'b0;
    chk("split done", 32'(done_o), 32'd1);
    @(negedge clk_i);
    chk("split ready_after", 32'(req_ready_o), 32'd1);
    chk("split done_count", 32'(done_cnt - d0), 32'd1);
  endtask
`endif

  initial begin
    int d0;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_size_i  = '0;
    bus_ready_i = 1'b0;
    bus_ack_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst bus_valid", 32'(bus_valid_o), 32'd0);
    chk("rst bus_addr", bus_addr_o, 32'd0);
    chk("rst bus_wdata", bus_wdata_o, 32'd0);
    chk("rst bus_be", 32'(bus_be_o), 32'd0);
    chk("rst pulses", {29'd0, done_o, misalign_o, err_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst ready", 32'(req_ready_o), 32'd1);

    tbl.push_back(mk(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 1'b0, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 0, 2));
    tbl.push_back(mk(32'h0000_2002, 32'h1234_5678, 2'b01, 1'b0, 32'h0000_2000, 32'h5678_5678, 4'b1100, 3, 1));
    tbl.push_back(mk(32'h0000_0000, 32'h0000_00A5, 2'b00, 1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 4'b0001, 0, 0));
    tbl.push_back(mk(32'h0000_5001, 32'h0000_0012, 2'b00, 1'b0, 32'h0000_5000, 32'h1212_1212, 4'b0010, 1, 0));
    tbl.push_back(mk(32'h0000_6000, 32'hFFFF_8001, 2'b01, 1'b0, 32'h0000_6000, 32'h8001_8001, 4'b0011, 0, 1));
    tbl.push_back(mk(32'h0000_7000, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 4'b1111, 0, 3));
    tbl.push_back(mk(32'h0000_0000, 32'h0BAD_0BAD, 2'b11, 1'b1, 32'h0, 32'h0, 4'b0000, 0, 0));
`ifndef MISALIGN_SPLIT_EN
    tbl.push_back(mk(32'h0000_3001, 32'hCAFE_F00D, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0000, 0, 0));
    tbl.push_back(mk(32'h0000_2001, 32'hCAFE_F00D, 2'b01, 1'b1, 32'h0, 32'h0, 4'b0000, 0, 0));
    tbl.push_back(mk(32'h0000_3002, 32'hCAFE_F00D, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0000, 0, 0));
`endif

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    run_timeout(1'b0);
    run_timeout(1'b1);

`ifdef MISALIGN_SPLIT_EN
    run_split();
`endif

    // Reset while ISSUE is waiting on bus_ready_i
    d0 = done_cnt;
    send(32'h0000_8000, 32'h0000_0055, 2'b10);
    chk("rstmid valid_before", 32'(bus_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid valid_async", 32'(bus_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    bus_ready_i = 1'b1;
    bus_ack_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    bus_ready_i = 1'b0;
    bus_ack_i   = 1'b0;
    chk("rstmid ready", 32'(req_ready_o), 32'd1);
    chk("rstmid no_valid", 32'(bus_valid_o), 32'd0);
    chk("rstmid no_done", 32'(done_cnt - d0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
